// File: rtl/signed_accumulator_pkg.sv
// Shared types and defaults for the signed accumulator and its flag generator.
package signed_accumulator_pkg;

  localparam int N_BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    OP_ADD   = 2'd0,
    OP_SUB   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/signed_accumulator_flag_gen.sv
// Combinational status flags for a signed N_BITS value.
module flag_gen #(
  parameter int N_BITS = 8
) (
  input  logic [N_BITS-1:0] value_i,
  output logic              is_negative_o,
  output logic              is_zero_o,
  output logic              is_even_o
);

  assign is_negative_o = value_i[N_BITS-1];
  assign is_zero_o     = (value_i == '0);
  assign is_even_o     = ~value_i[0];

endmodule

// File: rtl/signed_accumulator.sv
// Registered signed accumulator with wrap/saturate arithmetic, overflow flags
// and a one-entry valid/ready output stage.
module signed_accumulator
  import signed_accumulator_pkg::*;
#(
  parameter int N_BITS      = N_BITS_DEFAULT,
  parameter bit SAT_DEFAULT = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  input  logic [1:0]        in_op,
  input  logic              sat_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] acc,
  output logic              is_negative,
  output logic              is_zero,
  output logic              is_even,
  output logic              overflow,
  output logic              overflow_sticky
);

  localparam logic [N_BITS-1:0] AccMax = {1'b0, {(N_BITS-1){1'b1}}};
  localparam logic [N_BITS-1:0] AccMin = {1'b1, {(N_BITS-1){1'b0}}};

  state_t            state_q, state_d;
  logic [N_BITS-1:0] acc_q, acc_d;
  logic              ovf_q, ovf_d;
  logic              sticky_q, sticky_d;
  logic              isNeg_q, isZero_q, isEven_q;
  logic              isNeg_d, isZero_d, isEven_d;

  op_t               op;
  logic              accept;
  logic              satSel;
  logic              ovfDet;
  logic [N_BITS:0]   wide;
  logic [N_BITS:0]   accExt;
  logic [N_BITS:0]   dataExt;

  assign op       = op_t'(in_op);
  assign in_ready = (state_q == EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;
  // sat_en only matters on an accepting edge; otherwise fall back to the build default
  assign satSel   = accept ? sat_en : SAT_DEFAULT;

  assign accExt  = {acc_q[N_BITS-1], acc_q};
  assign dataExt = {in_data[N_BITS-1], in_data};

  // Next accumulator and overflow state; holds unless a beat is accepted.
  always_comb begin
    wide     = '0;
    ovfDet   = 1'b0;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    sticky_d = sticky_q;
    if (accept) begin
      case (op)
        OP_ADD, OP_SUB: begin
          wide   = (op == OP_ADD) ? (accExt + dataExt) : (accExt - dataExt);
          ovfDet = wide[N_BITS] ^ wide[N_BITS-1];
          if (ovfDet && satSel) begin
            acc_d = wide[N_BITS] ? AccMin : AccMax;
          end else begin
            acc_d = wide[N_BITS-1:0];
          end
          ovf_d    = ovfDet;
          sticky_d = sticky_q | ovfDet;
        end
        OP_LOAD: begin
          acc_d    = in_data;
          ovf_d    = 1'b0;
          sticky_d = 1'b0;
        end
        default: begin
          acc_d    = '0;
          ovf_d    = 1'b0;
          sticky_d = 1'b0;
        end
      endcase
    end
  end

  flag_gen #(.N_BITS(N_BITS)) u_flag_gen (
    .value_i       (acc_d),
    .is_negative_o (isNeg_d),
    .is_zero_o     (isZero_d),
    .is_even_o     (isEven_d)
  );

  // Output stage: a FULL slot is refilled in the same cycle it drains.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
      isNeg_q  <= 1'b0;
      isZero_q <= 1'b1;
      isEven_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
      isNeg_q  <= isNeg_d;
      isZero_q <= isZero_d;
      isEven_q <= isEven_d;
    end
  end

  assign out_valid       = (state_q == FULL);
  assign acc             = acc_q;
  assign is_negative     = isNeg_q;
  assign is_zero         = isZero_q;
  assign is_even         = isEven_q;
  assign overflow        = ovf_q;
  assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_signed_accumulator.sv
// Directed self-checking bench for signed_accumulator at N_BITS=8.
module tb_signed_accumulator;

  localparam int N = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [1:0]   in_op;
  logic         sat_en;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] acc;
  logic         is_negative;
  logic         is_zero;
  logic         is_even;
  logic         overflow;
  logic         overflow_sticky;

  int compared   = 0;
  int mismatched = 0;

  signed_accumulator #(.N_BITS(N), .SAT_DEFAULT(1'b0)) dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .in_op           (in_op),
    .sat_en          (sat_en),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .acc             (acc),
    .is_negative     (is_negative),
    .is_zero         (is_zero),
    .is_even         (is_even),
    .overflow        (overflow),
    .overflow_sticky (overflow_sticky)
  );

  always #5 clock = ~clock;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, LOAD = 2'd2, CLR = 2'd3;

  task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [N-1:0] d,
                               input logic s, input logic r);
    in_valid  = v;
    in_op     = op;
    in_data   = d;
    sat_en    = s;
    out_ready = r;
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [N-1:0] eAcc, input logic eOvf,
                             input logic eSticky, input logic eValid);
    checkOutput({tag, ".acc"}, 32'(acc), 32'(eAcc));
    checkOutput({tag, ".overflow"}, 32'(overflow), 32'(eOvf));
    checkOutput({tag, ".sticky"}, 32'(overflow_sticky), 32'(eSticky));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(eValid));
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, ADD, 8'd0, 1'b0, 1'b1);
    cycle();
    cycle();
    checkResult("in_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    cycle();
    checkResult("idle", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("idle.is_zero", 32'(is_zero), 32'd1);
    checkOutput("idle.is_even", 32'(is_even), 32'd1);
    checkOutput("idle.is_negative", 32'(is_negative), 32'd0);
    checkOutput("idle.in_ready", 32'(in_ready), 32'd1);

    // Wrapping overflow: 100 + 50 -> -106
    applyStimulus(1'b1, LOAD, 8'd100, 1'b0, 1'b1);
    cycle();
    checkResult("load100", 8'd100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, ADD, 8'd50, 1'b0, 1'b1);
    cycle();
    checkResult("wrap_add", 8'h96, 1'b1, 1'b1, 1'b1);
    checkOutput("wrap_add.is_negative", 32'(is_negative), 32'd1);
    checkOutput("wrap_add.is_even", 32'(is_even), 32'd1);
    checkOutput("wrap_add.is_zero", 32'(is_zero), 32'd0);

    // Saturating overflow, repeated at the bound, then recovery
    applyStimulus(1'b1, LOAD, 8'd100, 1'b1, 1'b1);
    cycle();
    checkResult("reload100", 8'd100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, ADD, 8'd50, 1'b1, 1'b1);
    cycle();
    checkResult("sat_add", 8'h7F, 1'b1, 1'b1, 1'b1);
    checkOutput("sat_add.is_even", 32'(is_even), 32'd0);
    applyStimulus(1'b1, ADD, 8'd5, 1'b1, 1'b1);
    cycle();
    checkResult("sat_hold", 8'h7F, 1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, ADD, 8'hE5, 1'b1, 1'b1);
    cycle();
    checkResult("add_m27", 8'd100, 1'b0, 1'b1, 1'b1);

    // Negative bound: -128 - 1
    applyStimulus(1'b1, LOAD, 8'h80, 1'b1, 1'b1);
    cycle();
    checkResult("load_m128", 8'h80, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, SUB, 8'd1, 1'b1, 1'b1);
    cycle();
    checkResult("sat_sub", 8'h80, 1'b1, 1'b1, 1'b1);
    checkOutput("sat_sub.is_negative", 32'(is_negative), 32'd1);
    applyStimulus(1'b1, LOAD, 8'h80, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b1, SUB, 8'd1, 1'b0, 1'b1);
    cycle();
    checkResult("wrap_sub", 8'h7F, 1'b1, 1'b1, 1'b1);
    checkOutput("wrap_sub.is_negative", 32'(is_negative), 32'd0);
    applyStimulus(1'b1, CLR, 8'h55, 1'b0, 1'b1);
    cycle();
    checkResult("clear", 8'h00, 1'b0, 1'b0, 1'b1);
    checkOutput("clear.is_zero", 32'(is_zero), 32'd1);

    // Back-pressure: drain, load 5 into a stalled consumer, offer ADD 3
    applyStimulus(1'b0, ADD, 8'd0, 1'b0, 1'b1);
    cycle();
    checkOutput("drain.out_valid", 32'(out_valid), 32'd0);
    applyStimulus(1'b1, LOAD, 8'd5, 1'b0, 1'b0);
    cycle();
    checkResult("load5", 8'd5, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, ADD, 8'd3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall.in_ready", 32'(in_ready), 32'd0);
      cycle();
      checkOutput("stall.acc", 32'(acc), 32'd5);
      checkOutput("stall.is_even", 32'(is_even), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release.in_ready", 32'(in_ready), 32'd1);
    cycle();
    checkResult("release", 8'd8, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, ADD, 8'd3, 1'b0, 1'b1);
    cycle();
    checkResult("single_update", 8'd8, 1'b0, 1'b0, 1'b0);

    // Full-throughput stream, then asynchronous reset mid-stream
    applyStimulus(1'b1, CLR, 8'd0, 1'b0, 1'b1);
    cycle();
    applyStimulus(1'b1, ADD, 8'd1, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      checkResult("stream", 8'(i), 1'b0, 1'b0, 1'b1);
    end
    #2;
    reset = 1'b1;
    #1;
    checkResult("async_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("async_reset.is_zero", 32'(is_zero), 32'd1);
    cycle();
    cycle();
    checkResult("held_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, ADD, 8'd1, 1'b0, 1'b1);
    reset = 1'b0;
    cycle();
    checkResult("post_reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("post_reset.in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
